serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder built around the team's single-bit `full_adder` cell (ports `a`, `b`, `ci`, `s`, `co`). It accepts two WIDTH-bit operands and a carry-in through a valid/ready handshake. It feeds them LSB-first through the cell, one bit per clock, with a registered carry. It returns the WIDTH-bit sum and carry-out through a second valid/ready handshake, giving an area-cheap multi-bit add for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- `WIDTH`, default 8: operand and sum width in bits; legal range 2..32.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: reset, asynchronous assert, active-low.
- `in_valid`  input  1: operand bundle valid.
- `in_ready`  output  1: block can accept operands.
- `a_in`  input  WIDTH: operand A.
- `b_in`  input  WIDTH: operand B.
- `cin`  input  1: carry-in for bit 0.
- `out_valid`  output  1: result valid.
- `out_ready`  input  1: downstream accepts the result.
- `sum`  output  WIDTH: A + B + cin, modulo 2^WIDTH.
- `cout`  output  1: carry out of bit WIDTH-1.

## Operation
- States:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - RUN: both low.
  - DONE: `out_valid`=1, `in_ready`=0.
- IDLE -> RUN on `in_valid && in_ready`.
  - Latch `a_in` and `b_in` into shift registers `sa`/`sb`.
  - Latch `cin` into carry register `c`.
  - Clear bit counter `cnt`, width $clog2(WIDTH).
  - Clear sum shift register `ss`.
- RUN, each cycle:
  - Cell inputs are `a`=`sa[0]`, `b`=`sb[0]`, `ci`=`c`.
  - `c` <= `co`.
  - `ss` <= {`s`, `ss[WIDTH-1:1]`}: shift right, new bit enters at MSB.
  - `sa` and `sb` shift right by 1.
  - `cnt` increments.
- RUN -> DONE on the cycle with `cnt`==WIDTH-1. That cycle's bit and carry are captured as usual.
- In DONE, `sum`=`ss` and `cout`=`c`. Both are held stable while `out_valid`=1 and `out_ready`=0; backpressure is unbounded.
- DONE -> IDLE on `out_ready`=1.
- `in_valid` is ignored outside IDLE. Upstream must hold its data until the handshake completes.
- Arithmetic:
  - Full WIDTH+1-bit result equals {`cout`, `sum`}.
  - Overflow is reported only through `cout`; there is no signed-overflow flag.
- Reset, at any time including mid-RUN or in DONE, returns the block to IDLE and discards the operation. No partial result is ever presented.

## Timing
- Reset values:
  - state=IDLE.
  - `in_ready`=1, `out_valid`=0.
  - `sum`=0, `cout`=0.
  - `sa`, `sb`, `c`, `cnt` all 0.
- `in_ready` and `out_valid` are decoded from state registers only. There is no combinational path from `in_valid` or `out_ready`.
- Latency: operands accepted at edge k produce `out_valid`=1 after edge k+WIDTH.
- Result handshake at edge m puts `in_ready`=1 after edge m. The next accept is at edge m+1 at the earliest.
- Minimum initiation interval is WIDTH+2 cycles (accept, WIDTH RUN cycles, one-cycle DONE).
- No bypass. The block never accepts new operands in the same cycle a result is consumed.

## Structure
- Shared header/package carries:
  - State encodings `ST_IDLE`=2'd0, `ST_RUN`=2'd1, `ST_DONE`=2'd2, as named constants.
  - A `CNT_W` computation helper.
- Encoding 2'd3 is illegal and recovers to IDLE on the next edge.
- One sub-module: the existing `full_adder`, instantiated once. The carry register, shift registers, counter and FSM live in `serial_adder`.
- Behavioural addition is not allowed in place of the cell; this exercises the cell in a sequential context.

## Test plan
All scenarios use WIDTH=8.
- Reset then idle: `rst_n` low for 3 cycles, release. Expect `in_ready`=1, `out_valid`=0, `sum`=0x00, `cout`=0.
- Basic add: `a_in`=0x5A, `b_in`=0x3C, `cin`=0, `out_ready`=1. Expect `out_valid` 8 edges after accept with `sum`=0x96, `cout`=0, then `in_ready`=1 one edge later.
- Carry ripple: 0xFF + 0x01, `cin`=0 -> `sum`=0x00, `cout`=1. Then 0xFF + 0xFF, `cin`=1 -> `sum`=0xFF, `cout`=1.
- Backpressure: 0x12 + 0x34 with `out_ready`=0 for 5 cycles after `out_valid`. Expect `sum`=0x46 and `cout`=0 held stable, `in_ready`=0 throughout, and a change of `in_valid`/`a_in` during this time ignored.
- Reset mid-operation: accept 0x80 + 0x80, assert `rst_n` low after 4 RUN cycles. Expect immediate `out_valid`=0 and `in_ready`=1 after release, with no result ever presented. A following 0x01 + 0x02 yields 0x03.
- Back-to-back: hold `in_valid`=1 with three operand pairs and `out_ready`=1 tied high. Expect results in order, with accepts spaced exactly 10 cycles apart.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and
// the helper that sizes the bit counter from the operand width.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Counter width needed to count 0..width-1; never narrower than one bit.
  function automatic int calc_cnt_w(input int width);
    if (width <= 2) begin
      return 1;
    end
    return $clog2(width);
  endfunction

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell: s = a ^ b ^ ci, co = majority(a, b, ci).
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: operands are latched on an input handshake, fed LSB-first
// through one full_adder cell with a registered carry, and the assembled sum
// and carry-out are offered on an output handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = calc_cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] ss_q, ss_d;
  logic             c_q, c_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             fa_s;
  logic             fa_co;

  full_adder u_full_adder (
    .a  (sa_q[0]),
    .b  (sb_q[0]),
    .ci (c_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // State, shift registers, carry and counter; reset discards any operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      ss_q    <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      ss_q    <= ss_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and datapath control; handshake outputs depend on state only.
  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    ss_d      = ss_q;
    c_d       = c_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sum       = '0;
    cout      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_RUN;
          sa_d    = a_in;
          sb_d    = b_in;
          c_d     = cin;
          cnt_d   = '0;
          ss_d    = '0;
        end
      end
      ST_RUN: begin
        c_d   = fa_co;
        ss_d  = {fa_s, ss_q[WIDTH-1:1]};
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        cnt_d = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        sum       = ss_q;
        cout      = c_q;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_serial_adder.sv
// Testbench for serial_adder at WIDTH=8: directed vector table plus
// hand-written sequences for backpressure, mid-run reset and back-to-back use.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int totalCount = 0;
  int badCount   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] expSum;
    logic       expCout;
    string      name;
  } vec_t;

  vec_t vecs [0:7];

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One comparison: counts it, and reports a FAIL line on mismatch.
  task automatic checkOutput(input string name, input logic [32:0] actual,
                             input logic [32:0] expected);
    totalCount++;
    if (actual !== expected) begin
      badCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offers one operand bundle and returns just after the accepting edge.
  task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b,
                               input logic c, input string name);
    int waitCycles;
    waitCycles = 0;
    while (!in_ready && waitCycles < 40) begin
      @(posedge clk); #1;
      waitCycles++;
    end
    checkOutput({name, "_ready_wait"}, 33'(in_ready), 33'd1);
    a_in     = a;
    b_in     = b;
    cin      = c;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Waits for the result, checking latency, sum and carry-out.
  task automatic collectResult(input logic [7:0] expSum, input logic expCout,
                               input string name);
    int cycles;
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput({name, "_latency"}, 33'(cycles), 33'd8);
    checkOutput({name, "_sum"}, 33'(sum), 33'(expSum));
    checkOutput({name, "_cout"}, 33'(cout), 33'(expCout));
  endtask

  logic       sawValid;
  int         acceptCycle [0:2];
  logic [7:0] bbA [0:2];
  logic [7:0] bbB [0:2];
  logic       bbC [0:2];
  logic [7:0] bbSum [0:2];
  logic       bbCout [0:2];

  initial begin
    vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "basic"};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "ripple1"};
    vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "ripple2"};
    vecs[3] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, "cin_only"};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, "msb_carry"};
    vecs[5] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, "alternate"};
    vecs[6] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0, "mid_ripple"};
    vecs[7] = '{8'hC3, 8'h3D, 1'b0, 8'h00, 1'b1, "full_wrap"};

    bbA[0] = 8'h01; bbB[0] = 8'h01; bbC[0] = 1'b0; bbSum[0] = 8'h02; bbCout[0] = 1'b0;
    bbA[1] = 8'h10; bbB[1] = 8'h20; bbC[1] = 1'b1; bbSum[1] = 8'h31; bbCout[1] = 1'b0;
    bbA[2] = 8'hF0; bbB[2] = 8'h20; bbC[2] = 1'b0; bbSum[2] = 8'h10; bbCout[2] = 1'b1;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    b_in      = '0;
    cin       = 1'b0;
    out_ready = 1'b1;

    // Reset then idle.
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("reset_in_ready", 33'(in_ready), 33'd1);
    checkOutput("reset_out_valid", 33'(out_valid), 33'd0);
    checkOutput("reset_sum", 33'(sum), 33'd0);
    checkOutput("reset_cout", 33'(cout), 33'd0);

    // Table of directed vectors with the result consumed immediately.
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].name);
      collectResult(vecs[i].expSum, vecs[i].expCout, vecs[i].name);
      @(posedge clk); #1;
      checkOutput({vecs[i].name, "_in_ready_after"}, 33'(in_ready), 33'd1);
      checkOutput({vecs[i].name, "_out_valid_after"}, 33'(out_valid), 33'd0);
    end

    // Backpressure: result held for 5 cycles while in_valid/a_in wiggle.
    out_ready = 1'b0;
    applyStimulus(8'h12, 8'h34, 1'b0, "bp");
    collectResult(8'h46, 1'b0, "bp");
    in_valid = 1'b1;
    a_in     = 8'hFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_hold_valid", 33'(out_valid), 33'd1);
      checkOutput("bp_hold_sum", 33'(sum), 33'h46);
      checkOutput("bp_hold_cout", 33'(cout), 33'd0);
      checkOutput("bp_hold_in_ready", 33'(in_ready), 33'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bp_release_in_ready", 33'(in_ready), 33'd1);
    checkOutput("bp_release_out_valid", 33'(out_valid), 33'd0);

    // Reset in the middle of a run discards the operation.
    applyStimulus(8'h80, 8'h80, 1'b0, "midrst");
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", 33'(out_valid), 33'd0);
    checkOutput("midrst_in_ready", 33'(in_ready), 33'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) sawValid = 1'b1;
    end
    checkOutput("midrst_no_result", 33'(sawValid), 33'd0);
    checkOutput("midrst_sum_cleared", 33'(sum), 33'd0);
    applyStimulus(8'h01, 8'h02, 1'b0, "post_rst");
    collectResult(8'h03, 1'b0, "post_rst");
    @(posedge clk); #1;

    // Back-to-back operands with in_valid held high and out_ready tied high.
    begin
      int cyc;
      int idx;
      int resIdx;
      logic acceptNow;
      cyc    = 0;
      idx    = 0;
      resIdx = 0;
      a_in     = bbA[0];
      b_in     = bbB[0];
      cin      = bbC[0];
      in_valid = 1'b1;
      while (resIdx < 3 && cyc < 100) begin
        acceptNow = in_valid && in_ready;
        if (out_valid && out_ready) begin
          checkOutput("b2b_sum", 33'(sum), 33'(bbSum[resIdx]));
          checkOutput("b2b_cout", 33'(cout), 33'(bbCout[resIdx]));
          resIdx++;
        end
        @(posedge clk); #1;
        cyc++;
        if (acceptNow && idx < 3) begin
          acceptCycle[idx] = cyc;
          idx++;
          if (idx < 3) begin
            a_in = bbA[idx];
            b_in = bbB[idx];
            cin  = bbC[idx];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      in_valid = 1'b0;
      checkOutput("b2b_results", 33'(resIdx), 33'd3);
      checkOutput("b2b_accepts", 33'(idx), 33'd3);
      if (idx == 3) begin
        checkOutput("b2b_spacing01", 33'(acceptCycle[1] - acceptCycle[0]), 33'd10);
        checkOutput("b2b_spacing12", 33'(acceptCycle[2] - acceptCycle[1]), 33'd10);
      end
    end

    $display("test done: total=%0d bad=%0d", totalCount, badCount);
    $finish;
  end

endmodule
